scalar_ex_commit: RTL and testbench

//  Scalar execute-commit stage, directly downstream of the scalar ALU.

---
 rtl/scalar_ex_commit.sv | 128 ++++++++++++
 tb/tb_scalar_ex_commit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_ex_commit.sv
// Scalar execute-commit stage, directly downstream of the scalar ALU.
// Registers the control-flow outcome into a one-cycle redirect pulse, buffers
// register writebacks in a 2-entry in-order FIFO toward the register-file
// write arbiter, squashes the wrong-path instruction after a taken
// branch/jump, and counts retired instructions.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              ALU result handshake
//   in_pc, in_imm, in_rd           instruction PC, immediate, destination
//   in_is_branch/jal/jalr          control-flow class (at most one set)
//   in_alu_result, in_branch_taken ALU outputs
//   flush_i                        external pipeline flush
//   wb_valid/wb_ready, wb_rd, wb_data   writeback request toward arbiter
//   redir_valid, redir_pc          one-cycle redirect pulse and target
//   retired_cnt                    retired-instruction counter
module scalar_ex_commit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_is_branch,
  input  logic              in_is_jal,
  input  logic              in_is_jalr,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic              in_branch_taken,
  input  logic              flush_i,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              redir_valid,
  output logic [XLEN-1:0]   redir_pc,
  output logic [31:0]       retired_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              squash;

  logic              accept;
  logic              keep;
  logic              taken_cf;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   push_data;

  // Handshake and decode of the incoming instruction
  always_comb begin
    in_ready  = ~rst & (count < CNT_W'(DEPTH));
    accept    = in_valid & in_ready & ~flush_i;
    keep      = accept & ~squash;
    taken_cf  = (in_is_branch & in_branch_taken) | in_is_jal | in_is_jalr;
    push      = keep & ~in_is_branch & (in_rd != '0);
    wb_valid  = (count != '0);
    pop       = wb_valid & wb_ready;
    // JALR target has bit 0 cleared; branches and JAL are PC-relative
    target    = in_is_jalr ? (in_alu_result & ~XLEN'(1)) : (in_pc + in_imm);
    push_data = (in_is_jal | in_is_jalr) ? (in_pc + XLEN'(4)) : in_alu_result;
    wb_rd     = rd_mem[head];
    wb_data   = data_mem[head];
  end

  // Writeback FIFO, redirect pulse, squash flag and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      squash      <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      retired_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_mem[i] <= '0;
        rd_mem[i]   <= '0;
      end
    end else if (flush_i) begin
      // Flush beats accept and pop; the retire count is left untouched
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      squash      <= 1'b0;
      redir_valid <= 1'b0;
    end else begin
      redir_valid <= keep & taken_cf;
      if (keep & taken_cf) begin
        redir_pc <= target;
      end

      // The one instruction right behind a taken control transfer is dropped;
      // an idle redirect cycle means the wrong-path slot went by empty.
      if (accept) begin
        squash <= ~squash & taken_cf;
      end else if (redir_valid) begin
        squash <= 1'b0;
      end

      if (keep) begin
        retired_cnt <= retired_cnt + 32'd1;
      end

      if (push) begin
        data_mem[tail] <= push_data;
        rd_mem[tail]   <= in_rd;
        tail           <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_scalar_ex_commit.sv
// Self-checking bench for scalar_ex_commit: a reference model of the stage
// runs alongside the DUT; expected writebacks are queued when an instruction
// is accepted and popped when the arbiter side takes them.
module tb_scalar_ex_commit;

  localparam int K_ALU  = 0;
  localparam int K_BR   = 1;
  localparam int K_JAL  = 2;
  localparam int K_JALR = 3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic        in_is_branch;
  logic        in_is_jal;
  logic        in_is_jalr;
  logic [31:0] in_alu_result;
  logic        in_branch_taken;
  logic        flush_i;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [31:0] retired_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  wb_t         wbq[$];
  int          mcount;
  bit          mredir;
  logic [31:0] mredir_pc;
  bit          msq;
  logic [31:0] mretired;
  bit          last_acc;

  scalar_ex_commit dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_imm          (in_imm),
    .in_rd           (in_rd),
    .in_is_branch    (in_is_branch),
    .in_is_jal       (in_is_jal),
    .in_is_jalr      (in_is_jalr),
    .in_alu_result   (in_alu_result),
    .in_branch_taken (in_branch_taken),
    .flush_i         (flush_i),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .redir_valid     (redir_valid),
    .redir_pc        (redir_pc),
    .retired_cnt     (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, advance the model, step past the edge
  task automatic tick();
    bit  acc;
    bit  pop;
    bit  nredir;
    bit  tcf;
    wb_t e;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(!rst && mcount < 2));
    check("wb_valid", 32'(wb_valid), 32'(mcount != 0));
    check("redir_valid", 32'(redir_valid), 32'(mredir));
    check("retired_cnt", retired_cnt, mretired);
    if (mredir) check("redir_pc", redir_pc, mredir_pc);
    pop = wb_ready && (mcount != 0);
    if (pop && wb_valid) begin
      e = wbq.pop_front();
      check("wb_rd", 32'(wb_rd), 32'(e.rd));
      check("wb_data", wb_data, e.data);
    end
    acc = in_valid && !rst && (mcount < 2) && !flush_i;
    last_acc = acc;
    if (rst) begin
      wbq.delete(); mcount = 0; mredir = 0; msq = 0; mretired = 0;
    end else if (flush_i) begin
      wbq.delete(); mcount = 0; mredir = 0; msq = 0;
    end else begin
      nredir = 0;
      if (pop) mcount--;
      if (acc && msq) begin
        msq = 0;
      end else if (acc) begin
        mretired = mretired + 32'd1;
        tcf = (in_is_branch && in_branch_taken) || in_is_jal || in_is_jalr;
        msq = tcf;
        if (tcf) begin
          nredir = 1;
          mredir_pc = in_is_jalr ? {in_alu_result[31:1], 1'b0} : in_pc + in_imm;
        end
        if (!in_is_branch && in_rd != 5'd0) begin
          wbq.push_back('{rd: in_rd,
                          data: (in_is_jal || in_is_jalr) ? in_pc + 32'd4 : in_alu_result});
          mcount++;
        end
      end else if (mredir) begin
        msq = 0;
      end
      mredir = nredir;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [31:0] alu, input bit taken);
    in_valid        = 1'b1;
    in_pc           = pc;
    in_imm          = imm;
    in_rd           = rd;
    in_alu_result   = alu;
    in_is_branch    = (kind == K_BR);
    in_is_jal       = (kind == K_JAL);
    in_is_jalr      = (kind == K_JALR);
    in_branch_taken = taken;
  endtask

  task automatic wait_acc();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = last_acc;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic issue(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [31:0] alu, input bit taken);
    drive(kind, pc, imm, rd, alu, taken);
    wait_acc();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset(input bit in_rst);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_redir_valid", 32'(redir_valid), 32'd0);
    check("rst_redir_pc", redir_pc, 32'd0);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'(!in_rst));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush_i = 1'b0; wb_ready = 1'b1;
    drive(K_ALU, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
    in_valid = 1'b0;
    mcount = 0; mredir = 0; mredir_pc = '0; msq = 0; mretired = '0; last_acc = 0;
    @(posedge clk); #1;
    idle(2);
    chk_reset(1'b1);
    rst = 1'b0;
    tick();
    chk_reset(1'b0);

    // Plain ALU writeback
    issue(K_ALU, 32'h0000_0040, 32'd0, 5'd5, 32'h0000_1234, 1'b0);
    check("add_wb_valid", 32'(wb_valid), 32'd1);
    check("add_wb_data", wb_data, 32'h0000_1234);
    check("add_retired", retired_cnt, 32'd1);
    idle(2);

    // Taken BEQ followed by a wrong-path ADD that must vanish
    issue(K_BR, 32'h0000_0100, 32'h0000_0020, 5'd0, 32'd0, 1'b1);
    check("beq_redir_pc", redir_pc, 32'h0000_0120);
    issue(K_ALU, 32'h0000_0104, 32'd0, 5'd3, 32'h0000_0bad, 1'b0);
    idle(2);
    check("beq_retired", retired_cnt, 32'd2);

    // JALR: target bit 0 cleared, link = pc+4
    issue(K_JALR, 32'h0000_0200, 32'h0000_0005, 5'd1, 32'h0000_0305, 1'b0);
    check("jalr_redir_pc", redir_pc, 32'h0000_0304);
    check("jalr_wb_data", wb_data, 32'h0000_0204);
    idle(2);

    // Not-taken branch, JAL to x0, ALU to x0, wrapping branch target
    issue(K_BR, 32'h0000_0300, 32'h0000_0040, 5'd0, 32'd0, 1'b0);
    issue(K_JAL, 32'h0000_0304, 32'h0000_0100, 5'd0, 32'd0, 1'b0);
    idle(1);
    issue(K_ALU, 32'h0000_0404, 32'd0, 5'd0, 32'h0000_7777, 1'b0);
    issue(K_BR, 32'hFFFF_FFF0, 32'h0000_0020, 5'd0, 32'd0, 1'b1);
    check("wrap_redir_pc", redir_pc, 32'h0000_0010);
    idle(3);

    // Back-pressure: third ADD stalls until the arbiter drains
    wb_ready = 1'b0;
    issue(K_ALU, 32'h0000_0500, 32'd0, 5'd10, 32'h0000_00a1, 1'b0);
    issue(K_ALU, 32'h0000_0504, 32'd0, 5'd11, 32'h0000_00a2, 1'b0);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    drive(K_ALU, 32'h0000_0508, 32'd0, 5'd12, 32'h0000_00a3, 1'b0);
    idle(3);
    check("bp_hold_rd", 32'(wb_rd), 32'd10);
    wb_ready = 1'b1;
    wait_acc();
    idle(4);

    // Flush with a full FIFO and a redirect in flight; squash must not linger
    wb_ready = 1'b0;
    issue(K_ALU, 32'h0000_0600, 32'd0, 5'd6, 32'h0000_0606, 1'b0);
    issue(K_JAL, 32'h0000_0604, 32'h0000_0080, 5'd8, 32'd0, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_wb_valid", 32'(wb_valid), 32'd0);
    check("flush_redir_valid", 32'(redir_valid), 32'd0);
    check("flush_retired", retired_cnt, 32'd12);
    wb_ready = 1'b1;
    issue(K_ALU, 32'h0000_0700, 32'd0, 5'd9, 32'h0000_0909, 1'b0);
    idle(2);

    // Retire counter wrap
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt;
    mretired = 32'hFFFF_FFFF;
    tick();
    issue(K_ALU, 32'h0000_0800, 32'd0, 5'd0, 32'd0, 1'b0);
    check("wrap_retired", retired_cnt, 32'd0);

    // Reset in the middle of traffic
    wb_ready = 1'b0;
    issue(K_ALU, 32'h0000_0900, 32'd0, 5'd14, 32'h0000_0e0e, 1'b0);
    issue(K_JAL, 32'h0000_0904, 32'h0000_0010, 5'd15, 32'd0, 1'b0);
    rst = 1'b1;
    tick();
    chk_reset(1'b1);
    rst = 1'b0;
    wb_ready = 1'b1;
    tick();
    chk_reset(1'b0);
    idle(2);

    check("wbq_drained", 32'(wbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
